// File: rtl/register16.sv
// WIDTH-bit storage register: synchronous active-high reset beats load, load beats hold.
// Storage is built from WIDTH identical 1-bit cells, so every bit is captured on the same edge.

module register16_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic load,
  output logic q
);

  // The flop powers up at its reset bit, so q is defined before the first reset or load.
  logic q_r = RESET_BIT;
  logic mux_out;
  logic d_next;

  always_comb begin
    mux_out = load ? d : q_r;
    d_next  = reset ? RESET_BIT : mux_out;
  end

  always_ff @(posedge clk) begin
    q_r <= d_next;
  end

  assign q = q_r;

endmodule

module register16 #(
  parameter int                WIDTH       = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  // out comes straight from the cell flops; there is no combinational path from in, load or reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    register16_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .d     (in[i]),
      .load  (load),
      .q     (out[i])
    );
  end

endmodule

// File: tb/tb_register16.sv
// Bench for register16: a directed vector table, hand-written corner sequences,
// and random traffic checked against a next-state model held inside the bench.

module tb_register16;

  localparam int          W  = 16;
  localparam logic [W-1:0] RV = 16'h0000;

  // clock / reset block
  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         load  = 1'b0;
  logic [W-1:0] din   = 16'hABCD;
  logic [W-1:0] dout;

  always #5 clk = ~clk;

  register16 #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .load  (load),
    .out   (dout)
  );

  // scoreboard
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] model_q  = RV;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Model: what a register must hold after an edge, from the priority rules.
  function automatic logic [W-1:0] next_value(input logic r, input logic l,
                                             input logic [W-1:0] d, input logic [W-1:0] cur);
    if (r)      return RV;
    else if (l) return d;
    else        return cur;
  endfunction

  // driver: set inputs at the falling edge, confirm the old value is still visible
  // before the rising edge, then check the new value just after it.
  task automatic step(input string name, input logic r, input logic l, input logic [W-1:0] d);
    @(negedge clk);
    reset = r;
    load  = l;
    din   = d;
    #1;
    check({name, "_before_edge"}, dout, model_q);
    @(posedge clk);
    model_q = next_value(r, l, d, model_q);
    exp_q.push_back(model_q);
    #1;
    check(name, dout, exp_q.pop_front());
  endtask

  typedef struct {
    logic         r;
    logic         l;
    logic [W-1:0] d;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // power-up hold: no reset, load low, data present
    #1;
    check("powerup_initial", dout, RV);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("powerup_hold", dout, RV);
    end

    // directed table: expected values written out by hand
    vecs[0] = '{1'b0, 1'b1, 16'hABCD, 16'hABCD};
    vecs[1] = '{1'b0, 1'b0, 16'hABCE, 16'hABCD};
    vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 16'h1234, 16'h1234};
    vecs[5] = '{1'b1, 1'b1, 16'h5678, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 16'h5678, 16'h5678};
    vecs[7] = '{1'b1, 1'b0, 16'h9999, 16'h0000};
    vecs[8] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000};
    vecs[9] = '{1'b0, 1'b1, 16'hA5A5, 16'hA5A5};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = vecs[i].r;
      load  = vecs[i].l;
      din   = vecs[i].d;
      @(posedge clk);
      model_q = vecs[i].exp;
      #1;
      check($sformatf("vec%0d", i), dout, vecs[i].exp);
    end

    // mid-cycle isolation: wiggle in, load and reset between edges
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      din   = ~din;
      load  = ~load;
      reset = (i == 2);
      #1;
      check("midcycle_glitch", dout, model_q);
    end
    reset = 1'b0;
    load  = 1'b0;
    @(posedge clk);
    #1;
    check("midcycle_after_edge", dout, model_q);

    // periodic load: load alternates each edge, data advances every two edges
    for (int i = 0; i < 8; i++)
      step("periodic", 1'b0, (i % 2) == 0, 16'hABCD + W'(i / 2));

    // long reset ignores load and data, then loads immediately after release
    for (int i = 0; i < 3; i++)
      step("reset_held", 1'b1, 1'b1, W'($urandom));
    step("reset_release", 1'b0, 1'b1, 16'h0F0F);

    // random traffic against the model
    for (int i = 0; i < 200; i++)
      step("random", ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1), W'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register16.md
REGISTER16 -- requirements
Module: register16

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits.
REQ-002 Parameter RESET_VALUE, default 16'h0000 (WIDTH bits), value loaded by reset and at power-up.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state changes on its rising edge only.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in  input  WIDTH  data to be stored.
REQ-007 load  input  1  write enable; when 1 at a rising clk edge, in is captured.
REQ-008 out  output  WIDTH  currently stored value, driven directly from storage flops.

Function
REQ-009 On each rising clk edge the block SHALL update its state by priority:
- reset=1: out <= RESET_VALUE.
- else load=1: out <= in.
- else: out holds.
REQ-010 Reset SHALL take priority over load when both are 1 on the same edge.
REQ-011 Write latency SHALL be one cycle: a value captured at edge N appears on out just after edge N and stays stable until the next edge that resets or loads.
REQ-012 out SHALL have no combinational path from in, load or reset; changes between edges SHALL NOT affect out.
REQ-013 Read-during-write SHALL give the old value: when load=1, out carries the previous value up to the edge and the new value after it.
REQ-014 All WIDTH bits SHALL be captured together; no partial or per-bit writes.
REQ-015 Values SHALL be stored verbatim, including 0 and all-ones (16'hFFFF); no arithmetic, saturation or wrap is applied.
REQ-016 Storage SHALL start at RESET_VALUE at power-up or simulation start, so out is defined before the first reset or load.
REQ-017 An unconnected or low reset SHALL never clear state.
REQ-018 Storage SHALL be built as WIDTH identical 1-bit cells. Each cell is a D flop fed by a 2:1 mux selecting in[i] when load=1 and the flop output otherwise, with reset gating the flop input to RESET_VALUE[i].
REQ-019 A glitch on load or in between edges SHALL have no effect.

Reset
REQ-020 Reset SHALL be sampled only on rising clk edges; asserting it between edges changes nothing until the next edge.
REQ-021 After reset is sampled, out SHALL equal RESET_VALUE from that edge onward.
REQ-022 Reset held for several cycles SHALL keep out at RESET_VALUE regardless of load and in.
REQ-023 On the first edge with reset=0 and load=1, in SHALL be captured normally; no recovery cycles are needed.
REQ-024 Reset during a load, with reset and load both 1 on the same edge, SHALL discard in and give RESET_VALUE.

Verification
REQ-025 Power-up hold: load=0, no reset, in=16'hABCD for 3 edges -> out stays 16'h0000.
REQ-026 Basic load: in=16'hABCD, load=1 for one edge -> out=16'hABCD after that edge. Then in=16'hABCE with load=0 -> out stays 16'hABCD.
REQ-027 Periodic load: clk period 2, load toggling every 2 time units, in incrementing every 4 units from 16'hABCD -> out changes only on edges where load=1, each time to the in value present at that edge.
REQ-028 Wrap data: in=16'hFFFF loaded, then in=16'h0000 loaded -> out=16'hFFFF, then 16'h0000, with no stray values between edges.
REQ-029 Reset priority: out=16'h1234, then reset=1 and load=1 with in=16'h5678 -> out=16'h0000. Next edge reset=0, load=1 -> out=16'h5678.
REQ-030 Mid-cycle isolation: toggle in and load between edges with no edge in between -> out unchanged; reset pulsed between edges -> out unchanged.
